// File: rtl/accum_seq_ctrl.sv
// Accumulator controller closing the loop around an external ripple-carry adder.
// Optional saturating arithmetic enabled by defining ACCUM_SAT_EN.
module accum_seq_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_OPS = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic [WIDTH-1:0] acc,
  output logic             carry_flag,
  output logic             ovf_sticky,
  output logic [3:0]       op_count,
  output logic             done
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUM  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               ovf_now;

  // Adder drive: subtraction is acc + ~operand + 1
  assign add_a   = acc_q;
  assign add_b   = sub_q ? ~opnd_q : opnd_q;
  assign add_cin = sub_q;

  // A missing carry on subtract is a borrow
  assign ovf_now = sub_q ? ~add_cout : add_cout;

  assign in_ready   = (state_q == S_IDLE);
  assign acc        = acc_q;
  assign carry_flag = carry_q;
  assign ovf_sticky = ovf_q;
  assign op_count   = cnt_q;
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    done_d  = done_q;

    if (clear) begin
      // Restart discards any in-flight result
      state_d = S_IDLE;
      acc_d   = '0;
      opnd_d  = '0;
      sub_d   = 1'b0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            opnd_d  = in_data;
            sub_d   = in_sub;
            state_d = S_SUM;
          end
        end
        S_SUM: begin
`ifdef ACCUM_SAT_EN
          if (ovf_now) acc_d = sub_q ? '0 : '1;
          else         acc_d = add_s;
`else
          acc_d = add_s;
`endif
          carry_d = add_cout;
          ovf_d   = ovf_q | ovf_now;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(MAX_OPS)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed self-checking bench for accum_seq_ctrl with a behavioural 4-bit adder.
// Expected values follow the ACCUM_SAT_EN setting of the build.
module tb_accum_seq_ctrl;

  logic       clk;
  logic       resetn;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_sub;
  logic       in_ready;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_s;
  logic       add_cout;
  logic [3:0] acc;
  logic       carry_flag;
  logic       ovf_sticky;
  logic [3:0] op_count;
  logic       done;

  int tests = 0;
  int fails = 0;

  accum_seq_ctrl #(.WIDTH(4), .MAX_OPS(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sub     (in_sub),
    .in_ready   (in_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_s      (add_s),
    .add_cout   (add_cout),
    .acc        (acc),
    .carry_flag (carry_flag),
    .ovf_sticky (ovf_sticky),
    .op_count   (op_count),
    .done       (done)
  );

  // Stand-in for the attached ripple-carry adder
  always_comb {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation; returns the adder drive and in_ready seen during SUM
  task automatic op(input logic [3:0] d, input logic s,
                    output logic [3:0] sa, output logic [3:0] sb,
                    output logic scin, output logic srdy);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    @(negedge clk);
    in_valid = 1'b0;
    sa   = add_a;
    sb   = add_b;
    scin = add_cin;
    srdy = in_ready;
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic [3:0] sa, sb;
  logic       scin, srdy;
  bit         seen;

  initial begin
    resetn   = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'd0;
    in_sub   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_acc", 8'(acc), 8'd0);
    chk("rst_carry", 8'(carry_flag), 8'd0);
    chk("rst_ovf", 8'(ovf_sticky), 8'd0);
    chk("rst_cnt", 8'(op_count), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_ready", 8'(in_ready), 8'd1);
    resetn = 1'b1;

    // add 3, 4, 2
    op(4'd3, 1'b0, sa, sb, scin, srdy);
    op(4'd4, 1'b0, sa, sb, scin, srdy);
    op(4'd2, 1'b0, sa, sb, scin, srdy);
    chk("sum_acc", 8'(acc), 8'd9);
    chk("sum_cnt", 8'(op_count), 8'd3);
    chk("sum_ovf", 8'(ovf_sticky), 8'd0);
    chk("sum_ready", 8'(in_ready), 8'd1);

    // 12 + 7 overflows, then + 1
    do_clear();
    op(4'd12, 1'b0, sa, sb, scin, srdy);
    op(4'd7, 1'b0, sa, sb, scin, srdy);
`ifdef ACCUM_SAT_EN
    chk("wrap_acc", 8'(acc), 8'd15);
`else
    chk("wrap_acc", 8'(acc), 8'd3);
`endif
    chk("wrap_carry", 8'(carry_flag), 8'd1);
    chk("wrap_ovf", 8'(ovf_sticky), 8'd1);
    op(4'd1, 1'b0, sa, sb, scin, srdy);
`ifdef ACCUM_SAT_EN
    chk("wrap2_acc", 8'(acc), 8'd15);
    chk("wrap2_carry", 8'(carry_flag), 8'd1);
`else
    chk("wrap2_acc", 8'(acc), 8'd4);
    chk("wrap2_carry", 8'(carry_flag), 8'd0);
`endif
    chk("wrap2_ovf", 8'(ovf_sticky), 8'd1);

    // 5 - 2, then - 6 borrows
    do_clear();
    chk("clr_ovf", 8'(ovf_sticky), 8'd0);
    op(4'd5, 1'b0, sa, sb, scin, srdy);
    op(4'd2, 1'b1, sa, sb, scin, srdy);
    chk("sub_acc", 8'(acc), 8'd3);
    chk("sub_carry", 8'(carry_flag), 8'd1);
    chk("sub_ovf", 8'(ovf_sticky), 8'd0);
    op(4'd6, 1'b1, sa, sb, scin, srdy);
    chk("sub_drv_a", 8'(sa), 8'd3);
    chk("sub_drv_b", 8'(sb), 8'd9);
    chk("sub_drv_cin", 8'(scin), 8'd1);
    chk("sub_busy", 8'(srdy), 8'd0);
`ifdef ACCUM_SAT_EN
    chk("borrow_acc", 8'(acc), 8'd0);
`else
    chk("borrow_acc", 8'(acc), 8'd13);
`endif
    chk("borrow_carry", 8'(carry_flag), 8'd0);
    chk("borrow_ovf", 8'(ovf_sticky), 8'd1);
    chk("borrow_cnt", 8'(op_count), 8'd3);

    // 15 + 1
    do_clear();
    op(4'd15, 1'b0, sa, sb, scin, srdy);
    op(4'd1, 1'b0, sa, sb, scin, srdy);
`ifdef ACCUM_SAT_EN
    chk("sat_acc", 8'(acc), 8'd15);
`else
    chk("sat_acc", 8'(acc), 8'd0);
`endif
    chk("sat_ovf", 8'(ovf_sticky), 8'd1);

    // Continuous add 1 until done
    do_clear();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'd1;
    in_sub   = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("run_done_seen", 8'(seen), 8'd1);
    chk("run_cnt", 8'(op_count), 8'd8);
    chk("run_acc", 8'(acc), 8'd8);
    chk("run_ready", 8'(in_ready), 8'd0);
    repeat (4) @(negedge clk);
    chk("hold_acc", 8'(acc), 8'd8);
    chk("hold_cnt", 8'(op_count), 8'd8);
    chk("hold_done", 8'(done), 8'd1);
    in_valid = 1'b0;
    do_clear();
    chk("rclr_acc", 8'(acc), 8'd0);
    chk("rclr_cnt", 8'(op_count), 8'd0);
    chk("rclr_done", 8'(done), 8'd0);
    chk("rclr_carry", 8'(carry_flag), 8'd0);
    chk("rclr_ready", 8'(in_ready), 8'd1);

    // Clear during SUM, then reset+clear together during SUM
    for (int k = 0; k < 2; k++) begin
      do_clear();
      op(4'd12, 1'b0, sa, sb, scin, srdy);
      op(4'd8, 1'b0, sa, sb, scin, srdy);
      chk("pre_ovf", 8'(ovf_sticky), 8'd1);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 4'd9;
      in_sub   = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_busy", 8'(in_ready), 8'd0);
      clear = 1'b1;
      if (k == 1) resetn = 1'b0;
      @(negedge clk);
      clear  = 1'b0;
      resetn = 1'b1;
      chk("mid_acc", 8'(acc), 8'd0);
      chk("mid_cnt", 8'(op_count), 8'd0);
      chk("mid_ovf", 8'(ovf_sticky), 8'd0);
      chk("mid_carry", 8'(carry_flag), 8'd0);
      chk("mid_ready", 8'(in_ready), 8'd1);
    end

    // Still operational afterwards
    op(4'd6, 1'b0, sa, sb, scin, srdy);
    chk("post_acc", 8'(acc), 8'd6);
    chk("post_cnt", 8'(op_count), 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
